// File: rtl/fp_fixed_pkg.sv
// Float field constants, fixed-point defaults and the unpacked float view
// shared by the fp32 -> fixed converter and its shift/align helper.
package fp_fixed_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int EXP_MAX  = 255;

  localparam int DEF_INT_WIDTH  = 8;
  localparam int DEF_FRAC_WIDTH = 24;

  // Wide enough for exp - bias + FRAC_WIDTH - MANT_W in two's complement
  localparam int SHIFT_W = 12;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'd0,
    FP_ZERO   = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_t;

  // Denormals are flushed to zero along with +/-0.
  function automatic fp_class_t fp_classify(input fp32_t f);
    fp_class_t c;
    if (f.exp == '0) begin
      c = FP_ZERO;
    end else if (f.exp == EXP_W'(EXP_MAX)) begin
      c = (f.mant == '0) ? FP_INF : FP_NAN;
    end else begin
      c = FP_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_shift_align.sv
// Combinational {1,mant} barrel shifter: shift is two's complement, positive = left.
// Flags magnitudes beyond the signed output range (limit depends on the sign).
module fp_shift_align
  import fp_fixed_pkg::*;
#(
  parameter int OUT_WIDTH = DEF_INT_WIDTH + DEF_FRAC_WIDTH
) (
  input  logic [MANT_W:0]        sig,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   sign,
  output logic [OUT_WIDTH-1:0]   mag,
  output logic                   ovf
);

  localparam int WIDE_W = OUT_WIDTH + MANT_W + 1;
  localparam logic [WIDE_W-1:0] NEG_LIMIT = WIDE_W'(1) << (OUT_WIDTH - 1);
  localparam logic [WIDE_W-1:0] POS_LIMIT = NEG_LIMIT - WIDE_W'(1);

  logic              shift_right;
  logic [SHIFT_W-1:0] amt;
  logic [WIDE_W-1:0]  wide;
  logic [WIDE_W-1:0]  limit;

  assign shift_right = shift[SHIFT_W-1];
  assign amt         = shift_right ? (~shift + SHIFT_W'(1)) : shift;
  assign limit       = sign ? NEG_LIMIT : POS_LIMIT;

  always_comb begin
    wide = '0;
    mag  = '0;
    ovf  = 1'b0;
    if (shift_right) begin
      // Everything shifted past the hidden bit truncates to zero
      if (amt < SHIFT_W'(MANT_W + 1)) begin
        mag = OUT_WIDTH'(sig >> amt);
      end
    end else if (amt >= SHIFT_W'(OUT_WIDTH)) begin
      ovf = 1'b1;
    end else begin
      wide = WIDE_W'(sig) << amt;
      mag  = wide[OUT_WIDTH-1:0];
      ovf  = (wide > limit);
    end
  end

endmodule

// File: rtl/fp32_to_fixed_conv.sv
// Pipelined IEEE-754 single to signed Q(INT).(FRAC) converter for the CORDIC angle path.
// Three stages, advanced only on clk_en; no back-pressure, caller gates clk_en.
module fp32_to_fixed_conv
  import fp_fixed_pkg::*;
#(
  parameter int INT_WIDTH  = DEF_INT_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic                            clock,
  input  logic                            aclr,
  input  logic                            clk_en,
  input  logic [31:0]                     dataa,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] result,
  output logic                            valid,
  output logic                            overflow
);

  localparam int OUT_WIDTH = INT_WIDTH + FRAC_WIDTH;
  localparam int LATENCY   = 3;
  localparam int SHIFT_OFS = EXP_BIAS + MANT_W - FRAC_WIDTH;

  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MAX = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Stage 1: unpack and classify
  fp32_t              in_f;
  fp_class_t          in_cls;
  logic [SHIFT_W-1:0] in_shift;

  logic               s1_vld;
  logic               s1_sign;
  fp_class_t          s1_cls;
  logic [MANT_W:0]    s1_sig;
  logic [SHIFT_W-1:0] s1_shift;

  assign in_f     = dataa;
  assign in_cls   = fp_classify(in_f);
  assign in_shift = SHIFT_W'(in_f.exp) - SHIFT_W'(SHIFT_OFS);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      s1_vld   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= FP_ZERO;
      s1_sig   <= '0;
      s1_shift <= '0;
    end else if (clk_en) begin
      s1_vld   <= 1'b1;
      s1_sign  <= in_f.sign;
      s1_cls   <= in_cls;
      s1_sig   <= {1'b1, in_f.mant};
      s1_shift <= in_shift;
    end
  end

  // Stage 2: align magnitude and detect range overflow
  logic [OUT_WIDTH-1:0] align_mag;
  logic                 align_ovf;

  logic                 s2_vld;
  logic                 s2_sign;
  fp_class_t            s2_cls;
  logic [OUT_WIDTH-1:0] s2_mag;
  logic                 s2_ovf;

  fp_shift_align #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_align (
    .sig   (s1_sig),
    .shift (s1_shift),
    .sign  (s1_sign),
    .mag   (align_mag),
    .ovf   (align_ovf)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_cls  <= FP_ZERO;
      s2_mag  <= '0;
      s2_ovf  <= 1'b0;
    end else if (clk_en) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_mag  <= align_mag;
      s2_ovf  <= align_ovf;
    end
  end

  // Stage 3: sign, saturate, register outputs
  logic [OUT_WIDTH-1:0] res_c;
  logic                 ovf_c;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (s2_cls)
      FP_ZERO: begin
        res_c = '0;
        ovf_c = 1'b0;
      end
      FP_NAN: begin
        res_c = POS_MAX;
        ovf_c = 1'b1;
      end
      FP_INF: begin
        res_c = s2_sign ? NEG_MAX : POS_MAX;
        ovf_c = 1'b1;
      end
      default: begin
        if (s2_ovf) begin
          res_c = s2_sign ? NEG_MAX : POS_MAX;
          ovf_c = 1'b1;
        end else begin
          // -2^(OUT_WIDTH-1) negates onto itself, which is the wanted encoding
          res_c = s2_sign ? (~s2_mag + OUT_WIDTH'(1)) : s2_mag;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      result   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (clk_en) begin
      result   <= res_c;
      valid    <= s2_vld;
      overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed_conv.sv
// Directed-vector bench for fp32_to_fixed_conv: conversion values, saturation,
// specials, streaming with clk_en stalls and asynchronous clear.
module tb_fp32_to_fixed_conv;

  logic        clock;
  logic        aclr;
  logic        clk_en;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        valid;
  logic        overflow;

  int n_tests;
  int n_fail;

  fp32_to_fixed_conv dut (
    .clock    (clock),
    .aclr     (aclr),
    .clk_en   (clk_en),
    .dataa    (dataa),
    .result   (result),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Launch one sample and return the outputs #1 after the third enabled edge.
  task automatic convert(input logic [31:0] a, output logic [31:0] r,
                         output logic v, output logic o);
    @(negedge clock);
    dataa  = a;
    clk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    r = result;
    v = valid;
    o = overflow;
  endtask

  task automatic test_reset;
    aclr   = 1'b1;
    clk_en = 1'b1;
    dataa  = 32'h3F80_0000;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (result !== 32'h0 || valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: result=%h valid=%b ovf=%b, want 00000000/0/0",
               result, valid, overflow);
    end
    @(negedge clock);
    aclr = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] r;
    logic v, o;
    convert(32'h3F80_0000, r, v, o);
    n_tests++;
    if (r !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL one_result: got %h want 01000000", r);
    end
    n_tests++;
    if (v !== 1'b1) begin
      n_fail++;
      $display("FAIL one_valid: got %b want 1", v);
    end
    n_tests++;
    if (o !== 1'b0) begin
      n_fail++;
      $display("FAIL one_overflow: got %b want 0", o);
    end
    convert(32'hBF80_0000, r, v, o);
    n_tests++;
    if (r !== 32'hFF00_0000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL minus_one: got %h/%b want ff000000/0", r, o);
    end
  endtask

  // Table of {input, expected result, expected overflow}
  task automatic test_values;
    logic [31:0] vin [9];
    logic [31:0] vexp [9];
    logic        vovf [9];
    logic [31:0] r;
    logic v, o;
    vin[0] = 32'h4049_0FDB; vexp[0] = 32'h0324_3F6C; vovf[0] = 1'b0; // pi
    vin[1] = 32'h3F00_0000; vexp[1] = 32'h0080_0000; vovf[1] = 1'b0; // 0.5
    vin[2] = 32'h3080_0000; vexp[2] = 32'h0000_0000; vovf[2] = 1'b0; // 2^-30
    vin[3] = 32'h4348_0000; vexp[3] = 32'h7FFF_FFFF; vovf[3] = 1'b1; // 200
    vin[4] = 32'hC348_0000; vexp[4] = 32'h8000_0000; vovf[4] = 1'b1; // -200
    vin[5] = 32'hC300_0000; vexp[5] = 32'h8000_0000; vovf[5] = 1'b0; // -128
    vin[6] = 32'h4300_0000; vexp[6] = 32'h7FFF_FFFF; vovf[6] = 1'b1; // +128
    vin[7] = 32'hC049_0FDB; vexp[7] = 32'hFCDB_C094; vovf[7] = 1'b0; // -pi
    vin[8] = 32'h3380_0000; vexp[8] = 32'h0000_0001; vovf[8] = 1'b0; // 2^-24
    for (int i = 0; i < 9; i++) begin
      convert(vin[i], r, v, o);
      n_tests++;
      if (r !== vexp[i] || o !== vovf[i] || v !== 1'b1) begin
        n_fail++;
        $display("FAIL value_%0d in=%h: got %h/ovf %b/vld %b want %h/ovf %b/vld 1",
                 i, vin[i], r, o, v, vexp[i], vovf[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [31:0] vin [6];
    logic [31:0] vexp [6];
    logic        vovf [6];
    logic [31:0] r;
    logic v, o;
    vin[0] = 32'h0000_0000; vexp[0] = 32'h0000_0000; vovf[0] = 1'b0; // +0
    vin[1] = 32'h8000_0000; vexp[1] = 32'h0000_0000; vovf[1] = 1'b0; // -0
    vin[2] = 32'h0040_0000; vexp[2] = 32'h0000_0000; vovf[2] = 1'b0; // denormal
    vin[3] = 32'h7F80_0000; vexp[3] = 32'h7FFF_FFFF; vovf[3] = 1'b1; // +inf
    vin[4] = 32'hFF80_0000; vexp[4] = 32'h8000_0000; vovf[4] = 1'b1; // -inf
    vin[5] = 32'hFFC0_0000; vexp[5] = 32'h7FFF_FFFF; vovf[5] = 1'b1; // -NaN
    for (int i = 0; i < 6; i++) begin
      convert(vin[i], r, v, o);
      n_tests++;
      if (r !== vexp[i] || o !== vovf[i]) begin
        n_fail++;
        $display("FAIL special_%0d in=%h: got %h/ovf %b want %h/ovf %b",
                 i, vin[i], r, o, vexp[i], vovf[i]);
      end
    end
    convert(32'h7FC0_0000, r, v, o);
    n_tests++;
    if (r !== 32'h7FFF_FFFF || o !== 1'b1) begin
      n_fail++;
      $display("FAIL qnan: got %h/ovf %b want 7fffffff/ovf 1", r, o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    vin[0] = 32'h3F80_0000; vexp[0] = 32'h0100_0000;
    vin[1] = 32'h3F00_0000; vexp[1] = 32'h0080_0000;
    vin[2] = 32'h4049_0FDB; vexp[2] = 32'h0324_3F6C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      clk_en = 1'b1;
      dataa  = (i < 3) ? vin[i] : 32'h7F80_0000;
      @(posedge clock);
      #1;
      if (i >= 2) begin
        n_tests++;
        if (result !== vexp[i-2] || valid !== 1'b1 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_%0d: got %h/vld %b/ovf %b want %h/1/0",
                   i - 2, result, valid, overflow, vexp[i-2]);
        end
      end
    end
  endtask

  task automatic test_stall;
    // Stream 1.0, -1.0, 0.5, pi with a 4-cycle clk_en gap after the first output
    @(negedge clock); clk_en = 1'b1; dataa = 32'h3F80_0000;
    @(posedge clock);
    @(negedge clock); dataa = 32'hBF80_0000;
    @(posedge clock);
    @(negedge clock); dataa = 32'h3F00_0000;
    @(posedge clock);
    #1;
    n_tests++;
    if (result !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL stall_pre: got %h want 01000000", result);
    end
    @(negedge clock);
    clk_en = 1'b0;
    dataa  = 32'h4348_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      n_tests++;
      if (result !== 32'h0100_0000 || valid !== 1'b1 || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got %h/vld %b/ovf %b want 01000000/1/0",
                 i, result, valid, overflow);
      end
    end
    @(negedge clock); clk_en = 1'b1; dataa = 32'h4049_0FDB;
    @(posedge clock);
    #1;
    n_tests++;
    if (result !== 32'hFF00_0000) begin
      n_fail++;
      $display("FAIL stall_post_0: got %h want ff000000", result);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (result !== 32'h0080_0000) begin
      n_fail++;
      $display("FAIL stall_post_1: got %h want 00800000", result);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (result !== 32'h0324_3F6C || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_post_2: got %h/vld %b want 03243f6c/1", result, valid);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clock); clk_en = 1'b1; dataa = 32'h4348_0000;
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (valid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clear: vld %b ovf %b want 1/1", valid, overflow);
    end
    @(negedge clock);
    #2;
    aclr = 1'b1;
    #1;
    n_tests++;
    if (result !== 32'h0 || valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got %h/vld %b/ovf %b want 00000000/0/0",
               result, valid, overflow);
    end
    @(negedge clock);
    aclr   = 1'b0;
    clk_en = 1'b1;
    dataa  = 32'h3F80_0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      n_tests++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL refill_%0d: vld got %b want 0", i, valid);
      end
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (valid !== 1'b1 || result !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL refill_done: got %h/vld %b want 01000000/1", result, valid);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    aclr    = 1'b1;
    clk_en  = 1'b0;
    dataa   = '0;
    test_reset();
    test_basic();
    test_values();
    test_specials();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
